apb_gpio_bank: RTL and testbench
================================

// Module: apb_gpio_bank
// PURPOSE
//  Parametrised APB slave GPIO bank for the Zscale BeMicro system. Replaces the single fixed-address
//  LED register with WIDTH bidirectional pins: output, direction, synchronised input, atomic set and
//  clear, and programmable APB wait states. Sits on the core's APB port; pins go to LEDs, switches
//  or headers.
// PARAMETERS
//  WIDTH        8             pin count, 1..32; unused data bits read 0 and ignore writes
//  BASE_ADDR    32'h8000_0000 bank base; must be 256-byte aligned
//  RESET_OUT    32'h80        reset value of OUT[WIDTH-1:0]
//  RESET_DIR    32'hFF        reset value of DIR[WIDTH-1:0]; 1 = output
//  WAIT_STATES  0             extra ACCESS cycles before pready, 0..15
//  SYNC_STAGES  2             input synchroniser depth, 2..4
// PORTS
//  clk      in   1      clock
//  reset    in   1      asynchronous, active-high
//  psel     in   1      APB select
//  penable  in   1      APB enable (access phase)
//  pwrite   in   1      1 = write
//  paddr    in   32     byte address
//  pwdata   in   32     write data
//  prdata   out  32     read data; valid when pready=1; 0 otherwise
//  pready   out  1      transfer complete (registered)
//  pslverr  out  1      error; valid only with pready=1
//  gpio_in  in   WIDTH  asynchronous pin inputs
//  gpio_out out  WIDTH  OUT register
//  gpio_oe  out  WIDTH  DIR register (pad output enable)
//  irq      out  1      level interrupt; stuck 0 without GPIO_IRQ_EN
// BEHAVIOUR
//  Reset values: OUT=RESET_OUT, DIR=RESET_DIR, IRQ_EN=0, IRQ_STAT=0, prdata=0, pready=0, pslverr=0,
//   FSM=IDLE, synchroniser flops=0.
//  Register map (offset = paddr[7:0]): 0x00 OUT rw | 0x04 DIR rw | 0x08 IN ro | 0x0C SET wo
//   (OUT|=wd) | 0x10 CLR wo (OUT&=~wd) | 0x14 IRQ_EN rw | 0x18 IRQ_STAT w1c. Write-only regs read 0.
//  FSM IDLE->ACCESS on psel&!penable: load cnt=WAIT_STATES, pready<=(WAIT_STATES==0).
//   In ACCESS, while cnt!=0: decrement cnt; pready<=(cnt==1).
//   At the edge where psel&penable&pready: commit write or capture read, go to DONE.
//   DONE drives pready=0 for 1 cycle, then returns to IDLE.
//   Back-to-back transfer: min 3 cycles per transfer when WAIT_STATES=0.
//  prdata and pslverr are registered on the same edge as pready.
//  psel dropped in ACCESS: abort to IDLE, no commit.
//  pslverr=1 and no state change when: paddr[31:8]!=BASE_ADDR[31:8], unmapped offset,
//   paddr[1:0]!=0, write to IN, or access to 0x14/0x18 without GPIO_IRQ_EN.
//  IN = synchronised gpio_in after SYNC_STAGES cycles. IN reads the pin even where DIR=1.
//  Reset asserted mid-transfer: all state returns to reset values immediately; no commit.
// CONFIGURATION
//  Macro GPIO_IRQ_EN defined:
//   - Rising edge on synchronised IN[i] with IRQ_EN[i]=1 sets IRQ_STAT[i].
//   - irq = |(IRQ_STAT & IRQ_EN), registered.
//   - Edge set and W1C clear of the same bit in the same cycle: set wins.
//  Macro GPIO_IRQ_EN undefined: no edge logic, 0x14/0x18 unmapped (pslverr), irq tied 0.
// STRUCTURE
//  Package gpio_pkg: register offset localparams, FSM state encoding, register-field width.
//  Sub-module gpio_sync: SYNC_STAGES-deep flop chain, WIDTH wide, async reset to 0.
//   One instance on gpio_in.
//  Top: APB FSM, wait counter, address decode, registers, IRQ logic.
// TESTING
//  Reset only                                -> gpio_out=8'h80, gpio_oe=8'hFF, irq=0, pready=0.
//  Write 0x8000_0000=0x5A, WAIT_STATES=0     -> pready high in the first ACCESS cycle;
//                                               gpio_out=0x5A next cycle; pslverr=0.
//  OUT=0x5A, SET 0x81 then CLR 0x18          -> gpio_out=0xDB then 0xC3; read OUT returns 0xC3.
//  WAIT_STATES=3, read IN with gpio_in=0x3C  -> pready after 4 ACCESS cycles, prdata=0x3C.
//  Write 0x8000_0020 or 0x9000_0000          -> pslverr=1, no register changes.
//  GPIO_IRQ_EN, IRQ_EN=0x01, rising gpio_in[0] -> irq=1 within SYNC_STAGES+2 cycles;
//                                                 W1C 0x01 clears irq; clear same cycle as
//                                                 new edge -> bit stays set.

Source files
------------

// File: rtl/gpio_pkg.sv
// Shared definitions for the APB GPIO bank.
// Register offsets, APB FSM encoding, data width.
package gpio_pkg;

  localparam int DATA_W = 32;

  localparam logic [7:0] OFF_OUT  = 8'h00;
  localparam logic [7:0] OFF_DIR  = 8'h04;
  localparam logic [7:0] OFF_IN   = 8'h08;
  localparam logic [7:0] OFF_SET  = 8'h0C;
  localparam logic [7:0] OFF_CLR  = 8'h10;
  localparam logic [7:0] OFF_IEN  = 8'h14;
  localparam logic [7:0] OFF_IST  = 8'h18;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/gpio_sync.sv
// Multi-stage flop chain bringing async pins into clk.
// Async active-high reset clears every stage.
module gpio_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] ff [STAGES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++)
        ff[i] <= '0;
    end else begin
      ff[0] <= d;
      for (int i = 1; i < STAGES; i++)
        ff[i] <= ff[i-1];
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/apb_gpio_bank.sv
// APB slave GPIO bank: OUT/DIR/IN/SET/CLR, wait states.
// Edge interrupts built only with macro GPIO_IRQ_EN.
module apb_gpio_bank
  import gpio_pkg::*;
#(
  parameter int          WIDTH       = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter logic [31:0] RESET_OUT   = 32'h80,
  parameter logic [31:0] RESET_DIR   = 32'hFF,
  parameter int          WAIT_STATES = 0,
  parameter int          SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [31:0]       paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  input  logic [WIDTH-1:0]  gpio_in,
  output logic [WIDTH-1:0]  gpio_out,
  output logic [WIDTH-1:0]  gpio_oe,
  output logic              irq
);

  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic rdy_nx, serr_nx, commit, wr_en, err;
  logic [DATA_W-1:0] rdata_nx, rd;
  logic [WIDTH-1:0] out_q, dir_q, in_sync, wd;
  logic [7:0] off;
  logic sel_out, sel_dir, sel_in, sel_set, sel_clr;
  logic sel_ien, sel_ist;

  gpio_sync #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (gpio_in),
    .q     (in_sync)
  );

  assign off     = paddr[7:0];
  assign wd      = pwdata[WIDTH-1:0];
  assign sel_out = (off == OFF_OUT);
  assign sel_dir = (off == OFF_DIR);
  assign sel_in  = (off == OFF_IN);
  assign sel_set = (off == OFF_SET);
  assign sel_clr = (off == OFF_CLR);
  assign sel_ien = (off == OFF_IEN);
  assign sel_ist = (off == OFF_IST);

`ifdef GPIO_IRQ_EN
  logic [WIDTH-1:0] ien_q, ist_q, in_prev;
`endif

  always_comb begin
    rd  = '0;
    err = 1'b0;
    unique case (1'b1)
      sel_out: rd[WIDTH-1:0] = out_q;
      sel_dir: rd[WIDTH-1:0] = dir_q;
      sel_in: begin
        rd[WIDTH-1:0] = in_sync;
        err = pwrite;
      end
      sel_set, sel_clr: rd = '0;
`ifdef GPIO_IRQ_EN
      sel_ien: rd[WIDTH-1:0] = ien_q;
      sel_ist: rd[WIDTH-1:0] = ist_q;
`endif
      default: err = 1'b1;
    endcase
    if (paddr[31:8] != BASE_ADDR[31:8] ||
        paddr[1:0] != 2'b00)
      err = 1'b1;
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    rdy_nx   = 1'b0;
    rdata_nx = '0;
    serr_nx  = 1'b0;
    commit   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (psel && !penable) begin
          state_nx = S_ACCESS;
          cnt_nx   = 4'(WAIT_STATES);
          if (WAIT_STATES == 0) begin
            rdy_nx   = 1'b1;
            rdata_nx = err ? '0 : rd;
            serr_nx  = err;
          end
        end
      end
      S_ACCESS: begin
        if (!psel) begin
          state_nx = S_IDLE;
        end else if (pready) begin
          if (penable) begin
            commit   = 1'b1;
            state_nx = S_DONE;
          end else begin
            rdy_nx   = 1'b1;
            rdata_nx = prdata;
            serr_nx  = pslverr;
          end
        end else if (cnt != 4'd0) begin
          cnt_nx = cnt - 4'd1;
          if (cnt == 4'd1) begin
            rdy_nx   = 1'b1;
            rdata_nx = err ? '0 : rd;
            serr_nx  = err;
          end
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      pready  <= 1'b0;
      prdata  <= '0;
      pslverr <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      pready  <= rdy_nx;
      prdata  <= rdata_nx;
      pslverr <= serr_nx;
    end
  end

  // error decision was latched with pready; trust it
  assign wr_en = commit && pwrite && !pslverr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q <= RESET_OUT[WIDTH-1:0];
      dir_q <= RESET_DIR[WIDTH-1:0];
    end else if (wr_en) begin
      unique case (1'b1)
        sel_out: out_q <= wd;
        sel_dir: dir_q <= wd;
        sel_set: out_q <= out_q | wd;
        sel_clr: out_q <= out_q & ~wd;
        default: ;
      endcase
    end
  end

  assign gpio_out = out_q;
  assign gpio_oe  = dir_q;

`ifdef GPIO_IRQ_EN
  logic [WIDTH-1:0] rise, w1c;

  assign rise = in_sync & ~in_prev & ien_q;
  assign w1c  = (wr_en && sel_ist) ? wd : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ien_q   <= '0;
      ist_q   <= '0;
      in_prev <= '0;
      irq     <= 1'b0;
    end else begin
      in_prev <= in_sync;
      if (wr_en && sel_ien)
        ien_q <= wd;
      // a fresh edge outranks a same-cycle clear
      ist_q <= (ist_q & ~w1c) | rise;
      irq   <= |(ist_q & ien_q);
    end
  end
`else
  assign irq = 1'b0;
`endif

  logic unused_ok;
  assign unused_ok = &{1'b0, pwdata, sel_ien, sel_ist};

endmodule

// File: tb/tb_apb_gpio_bank.sv
// Directed bench for apb_gpio_bank.
// u_a: WAIT_STATES=0, u_b: WAIT_STATES=3; shared bus.
module tb_apb_gpio_bank;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic psel_a = 1'b0, psel_b = 1'b0;
  logic penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0;
  logic [7:0] gpio_in = '0;
  logic [31:0] prdata_a, prdata_b;
  logic pready_a, pready_b, pslverr_a, pslverr_b;
  logic [7:0] out_a, out_b, oe_a, oe_b;
  logic irq_a, irq_b;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  apb_gpio_bank u_a (
    .clk (clk), .reset (reset),
    .psel (psel_a), .penable (penable),
    .pwrite (pwrite), .paddr (paddr),
    .pwdata (pwdata), .prdata (prdata_a),
    .pready (pready_a), .pslverr (pslverr_a),
    .gpio_in (gpio_in), .gpio_out (out_a),
    .gpio_oe (oe_a), .irq (irq_a)
  );

  apb_gpio_bank #(.WAIT_STATES (3)) u_b (
    .clk (clk), .reset (reset),
    .psel (psel_b), .penable (penable),
    .pwrite (pwrite), .paddr (paddr),
    .pwdata (pwdata), .prdata (prdata_b),
    .pready (pready_b), .pslverr (pslverr_b),
    .gpio_in (gpio_in), .gpio_out (out_b),
    .gpio_oe (oe_b), .irq (irq_b)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h",
               tag, got, exp);
    end
  endtask

  task automatic apb(input bit b,
                     input logic wr,
                     input logic [31:0] a,
                     input logic [31:0] d,
                     output logic [31:0] rdat,
                     output logic err,
                     output int n);
    logic rdy;
    @(posedge clk); #1;
    if (b) psel_b = 1'b1;
    else   psel_a = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = a;
    pwdata  = d;
    @(posedge clk); #1;
    penable = 1'b1;
    n = 1;
    rdy = b ? pready_b : pready_a;
    while (!rdy && n < 40) begin
      @(posedge clk); #1;
      n++;
      rdy = b ? pready_b : pready_a;
    end
    chk("apb_ready", 32'(rdy), 32'd1);
    rdat = b ? prdata_b : prdata_a;
    err  = b ? pslverr_b : pslverr_a;
    @(posedge clk); #1;
    psel_a  = 1'b0;
    psel_b  = 1'b0;
    penable = 1'b0;
  endtask

  logic [31:0] r;
  logic e;
  int n;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", 32'(out_a), 32'h80);
    chk("rst_oe", 32'(oe_a), 32'hFF);
    chk("rst_irq", 32'(irq_a), 32'd0);
    chk("rst_pready", 32'(pready_a), 32'd0);
    chk("rst_prdata", prdata_a, 32'd0);
    chk("rst_slverr", 32'(pslverr_a), 32'd0);
    reset = 1'b0;

    apb(0, 1, 32'h8000_0000, 32'h5A, r, e, n);
    chk("wr_out_lat", n, 1);
    chk("wr_out_err", 32'(e), 0);
    chk("wr_out_pin", 32'(out_a), 32'h5A);

    apb(0, 1, 32'h8000_000C, 32'h81, r, e, n);
    chk("set_pin", 32'(out_a), 32'hDB);
    apb(0, 1, 32'h8000_0010, 32'h18, r, e, n);
    chk("clr_pin", 32'(out_a), 32'hC3);
    apb(0, 0, 32'h8000_0000, 0, r, e, n);
    chk("rd_out", r, 32'hC3);
    chk("rd_out_err", 32'(e), 0);
    apb(0, 0, 32'h8000_000C, 0, r, e, n);
    chk("rd_set_zero", r, 32'd0);

    apb(0, 1, 32'h8000_0004, 32'h0F, r, e, n);
    chk("dir_pin", 32'(oe_a), 32'h0F);
    apb(0, 0, 32'h8000_0004, 0, r, e, n);
    chk("rd_dir", r, 32'h0F);

    gpio_in = 8'h3C;
    repeat (4) @(posedge clk);
    apb(1, 0, 32'h8000_0008, 0, r, e, n);
    chk("ws_lat", n, 4);
    chk("ws_rd_in", r, 32'h3C);
    apb(0, 0, 32'h8000_0008, 0, r, e, n);
    chk("rd_in", r, 32'h3C);

    apb(0, 1, 32'h8000_0020, 32'hFF, r, e, n);
    chk("unmap_err", 32'(e), 1);
    apb(0, 1, 32'h9000_0000, 32'h00, r, e, n);
    chk("base_err", 32'(e), 1);
    apb(0, 1, 32'h8000_0001, 32'h00, r, e, n);
    chk("align_err", 32'(e), 1);
    apb(0, 1, 32'h8000_0008, 32'h00, r, e, n);
    chk("wr_in_err", 32'(e), 1);
    chk("err_no_chg", 32'(out_a), 32'hC3);

    // abort: drop psel mid wait-state
    @(posedge clk); #1;
    psel_b = 1'b1; pwrite = 1'b1;
    paddr = 32'h8000_0000; pwdata = 32'h11;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel_b = 1'b0; penable = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_rdy", 32'(pready_b), 0);
    chk("abort_out", 32'(out_b), 32'h80);
    apb(1, 0, 32'h8000_0000, 0, r, e, n);
    chk("abort_rd", r, 32'h80);

`ifdef GPIO_IRQ_EN
    apb(0, 1, 32'h8000_0014, 32'h01, r, e, n);
    chk("ien_err", 32'(e), 0);
    gpio_in = 8'h3D;
    n = 0;
    while (!irq_a && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    chk("irq_set", 32'(irq_a), 1);
    chk("irq_lat_ok", 32'(n <= 4), 1);
    apb(0, 1, 32'h8000_0018, 32'h01, r, e, n);
    repeat (2) @(posedge clk);
    #1;
    chk("irq_w1c", 32'(irq_a), 0);
    gpio_in = 8'h3C;
    repeat (4) @(posedge clk);
    #1;
    chk("irq_fall_quiet", 32'(irq_a), 0);
    gpio_in = 8'h3D;
    apb(0, 1, 32'h8000_0018, 32'h01, r, e, n);
    repeat (2) @(posedge clk);
    #1;
    chk("irq_set_wins", 32'(irq_a), 1);
    apb(0, 0, 32'h8000_0018, 0, r, e, n);
    chk("ist_rd", r, 32'h01);
`else
    apb(0, 1, 32'h8000_0014, 32'h01, r, e, n);
    chk("ien_unmap", 32'(e), 1);
    apb(0, 0, 32'h8000_0018, 0, r, e, n);
    chk("ist_unmap", 32'(e), 1);
    gpio_in = 8'h3D;
    repeat (5) @(posedge clk);
    #1;
    chk("irq_tied", 32'(irq_a), 0);
`endif

    // reset during ACCESS with pready high
    @(posedge clk); #1;
    psel_a = 1'b1; pwrite = 1'b1;
    paddr = 32'h8000_0000; pwdata = 32'h77;
    @(posedge clk); #1;
    penable = 1'b1;
    chk("pre_rst_rdy", 32'(pready_a), 1);
    reset = 1'b1;
    #1;
    chk("midrst_rdy", 32'(pready_a), 0);
    chk("midrst_out", 32'(out_a), 32'h80);
    chk("midrst_oe", 32'(oe_a), 32'hFF);
    @(posedge clk); #1;
    psel_a = 1'b0; penable = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_out", 32'(out_a), 32'h80);

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
